// File: rtl/context_memory.sv
// context_memory: JPEG-LS context parameter store (A,B,C,N,Nn) with self-initialization and registered reads
module context_memory #(
    parameter int Q_length     = 9,
    parameter int A_length     = 16,
    parameter int B_length     = 8,
    parameter int C_length     = 8,
    parameter int N_length     = 7,
    parameter int Nn_length    = 7,
    parameter int Context_rw   = 2,
    parameter int NUM_CONTEXTS = 367,
    parameter int RANGE        = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_req,
    input  logic                  read_Context_Memory,
    input  logic [Q_length-1:0]   Q_Read,
    input  logic [Context_rw-1:0] write_Context_Memory,
    input  logic [Q_length-1:0]   Q_Write,
    input  logic [A_length-1:0]   A_Write,
    input  logic [B_length-1:0]   B_Write,
    input  logic [C_length-1:0]   C_Write,
    input  logic [N_length-1:0]   N_Write,
    input  logic [Nn_length-1:0]  Nn_Write,
    output logic [A_length-1:0]   A_Read,
    output logic [B_length-1:0]   B_Read,
    output logic [C_length-1:0]   C_Read,
    output logic [N_length-1:0]   N_Read,
    output logic [Nn_length-1:0]  Nn_Read,
    output logic                  read_valid,
    output logic                  ready,
    output logic                  addr_error
);
    localparam int A_RAW = (RANGE + 32) >> 6;
    localparam logic [A_length-1:0] A_INIT = A_length'(A_RAW > 2 ? A_RAW : 2);
    localparam logic [N_length-1:0] N_INIT = N_length'(1);
    localparam logic [Q_length:0] LIMIT = (Q_length+1)'(NUM_CONTEXTS);
    localparam logic [Q_length-1:0] LAST = Q_length'(NUM_CONTEXTS - 1);

    typedef enum logic {INIT, READY} state_t;
    state_t state, state_next;
    logic [Q_length-1:0] init_count;

    logic [A_length-1:0]  a_mem  [NUM_CONTEXTS];
    logic [B_length-1:0]  b_mem  [NUM_CONTEXTS];
    logic [C_length-1:0]  c_mem  [NUM_CONTEXTS];
    logic [N_length-1:0]  n_mem  [NUM_CONTEXTS];
    logic [Nn_length-1:0] nn_mem [NUM_CONTEXTS];

    logic init_wr, accept, rd_in, wr_in, rd_ok, hit;
    logic [Context_rw-1:0] wsel;
    logic [Q_length-1:0] w_addr;

    always_ff @(posedge clk) begin
        if (!reset || init_req) begin
            state <= INIT;
            init_count <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_count <= init_count + 1'b1;
        end
    end

    always_comb state_next = (state == INIT && init_count == LAST) ? READY : state;

    always_comb begin
        ready = state == READY;
        init_wr = state == INIT;
    end

    // Requests are dropped during init and on an init_req edge
    assign accept = ready && !init_req;
    assign rd_in  = {1'b0, Q_Read} < LIMIT;
    assign wr_in  = {1'b0, Q_Write} < LIMIT;
    assign rd_ok  = accept && read_Context_Memory;
    assign wsel   = (accept && wr_in) ? write_Context_Memory : '0;
    assign hit    = Q_Write == Q_Read;
    assign w_addr = init_wr ? init_count : Q_Write;

    always_ff @(posedge clk) begin
        if (reset) begin
            if (init_wr || wsel != '0) a_mem[w_addr] <= init_wr ? A_INIT : A_Write;
            if (init_wr || wsel[0]) b_mem[w_addr] <= init_wr ? '0 : B_Write;
            if (init_wr || wsel[0]) c_mem[w_addr] <= init_wr ? '0 : C_Write;
            if (init_wr || wsel != '0) n_mem[w_addr] <= init_wr ? N_INIT : N_Write;
            if (init_wr || wsel[1]) nn_mem[w_addr] <= init_wr ? '0 : Nn_Write;
        end
    end

    // Write-first bypass on a same-index read picks up only the fields being written
    always_ff @(posedge clk) begin
        if (!reset) begin
            A_Read <= '0;
            B_Read <= '0;
            C_Read <= '0;
            N_Read <= '0;
            Nn_Read <= '0;
            read_valid <= 1'b0;
            addr_error <= 1'b0;
        end else begin
            read_valid <= rd_ok;
            addr_error <= !init_req && (addr_error || (rd_ok && !rd_in) ||
                          (accept && write_Context_Memory != '0 && !wr_in));
            if (rd_ok) begin
                A_Read <= !rd_in ? A_INIT : (hit && wsel != '0) ? A_Write : a_mem[Q_Read];
                B_Read <= !rd_in ? '0 : (hit && wsel[0]) ? B_Write : b_mem[Q_Read];
                C_Read <= !rd_in ? '0 : (hit && wsel[0]) ? C_Write : c_mem[Q_Read];
                N_Read <= !rd_in ? N_INIT : (hit && wsel != '0) ? N_Write : n_mem[Q_Read];
                Nn_Read <= !rd_in ? '0 : (hit && wsel[1]) ? Nn_Write : nn_mem[Q_Read];
            end
        end
    end
endmodule
